// File: rtl/store_merge_pkg.sv
// rtl/store_merge_pkg.sv - shared size codes, state encoding and widths for the store merge block
package store_merge_pkg;

    localparam int DATA_W = 32;
    localparam int WADDR_W = 30;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Reserved size and any store that straddles its natural alignment are rejected.
    function automatic logic is_bad_store(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_if.sv
// rtl/store_merge_if.sv - request-side and memory-side bundles for the store merge block
interface store_req_if;
    import store_merge_pkg::*;

    logic              start;
    logic [31:0]       addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              done;
    logic              fault;

    modport master (output start, addr, size, data_in, input ready, done, fault);
    modport slave  (input start, addr, size, data_in, output ready, done, fault);
endinterface

interface store_mem_if;
    import store_merge_pkg::*;

    logic [WADDR_W-1:0] mem_addr;
    logic               mem_rd;
    logic [DATA_W-1:0]  mem_rd_data;
    logic               mem_wr;
    logic [DATA_W-1:0]  mem_wr_data;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wr_data, input mem_rd_data);
    modport slave  (input mem_addr, mem_rd, mem_wr, mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - big-endian byte/halfword lane insertion into an existing word
module store_lane_merge
    import store_merge_pkg::*;
(
    input  logic [DATA_W-1:0] i_old_word,
    input  logic [DATA_W-1:0] i_new_data,
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_addr_lo,
    output logic [DATA_W-1:0] o_merged
);

    logic [DATA_W-1:0] w_merged;

    // Lane 0 is the most significant byte of the word.
    always_comb begin
        w_merged = i_old_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'b00:   w_merged[31:24] = i_new_data[7:0];
                    2'b01:   w_merged[23:16] = i_new_data[7:0];
                    2'b10:   w_merged[15:8]  = i_new_data[7:0];
                    default: w_merged[7:0]   = i_new_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1])
                    w_merged[15:0] = i_new_data[15:0];
                else
                    w_merged[31:16] = i_new_data[15:0];
            end
            SZ_WORD: w_merged = i_new_data;
            default: w_merged = i_old_word;
        endcase
    end

    assign o_merged = w_merged;

endmodule

// File: rtl/store_merge.sv
// rtl/store_merge.sv - narrow store into a word memory without byte enables via read-modify-write
module store_merge
    import store_merge_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    store_req_if.slave    req,
    store_mem_if.master   mem
);

    state_e            r_state;
    state_e            w_next;
    logic [31:0]       r_addr;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_data;
    logic              r_fault;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] w_merged;
    logic              w_accept;
    logic              w_bad;

    assign w_accept = (r_state == ST_IDLE) && req.start;
    assign w_bad    = is_bad_store(req.size, req.addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req.start) begin
                    if (w_bad)
                        w_next = ST_DONE;
                    else if (req.size == SZ_WORD)
                        w_next = ST_WRITE;
                    else
                        w_next = ST_READ;
                end
            end
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  w_next = ST_WRITE;
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    store_lane_merge u_lane_merge (
        .i_old_word (mem.mem_rd_data),
        .i_new_data (r_data),
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .o_merged   (w_merged)
    );

    // Word stores write the accepted data directly; narrow stores overwrite it in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_size    <= '0;
            r_data    <= '0;
            r_fault   <= 1'b0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_addr    <= req.addr;
            r_size    <= req.size;
            r_data    <= req.data_in;
            r_fault   <= w_bad;
            r_wr_data <= req.data_in;
        end else if (r_state == ST_WAIT) begin
            r_wr_data <= w_merged;
        end
    end

    assign req.ready       = (r_state == ST_IDLE);
    assign req.done        = (r_state == ST_DONE);
    assign req.fault       = (r_state == ST_DONE) && r_fault;
    assign mem.mem_rd      = (r_state == ST_READ);
    assign mem.mem_wr      = (r_state == ST_WRITE);
    assign mem.mem_addr    = r_addr[31:2];
    assign mem.mem_wr_data = r_wr_data;

endmodule
